bcd_display_conv: RTL and testbench

Parametrised, sequential binary-to-BCD converter that feeds the 8-digit seven-segment scanner. It replaces single-cycle divide/modulo digit extraction with an iterative shift-and-add-3 (double-dabble) engine. It adds a valid/ready handshake, overflow saturation and leading-zero blanking. It sits between the value source (volume, track time, counters) and the digit scanner, and holds its last result stable for scanning.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bcd_display_conv.sv | 121 ++++++++++++
 tb/tb_bcd_display_conv.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;
  localparam logic [3:0]  BCD_NINE       = 4'h9;

  // Ceiling log2, used to size the shift counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble cell: adds 3 to a digit of 5 or more, no carry out.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= 4'(BCD_ADJ_THRESH)) adj_c = 4'(digit + 4'(BCD_ADJ_ADD));
  end

endmodule

// File: rtl/bcd_display_conv.sv
// Iterative binary-to-BCD converter with valid/ready input, overflow saturation
// and optional leading-zero blanking of digit_en (build with BCD_LZB_EN).
module bcd_display_conv
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BIN_W-1:0]      idata,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = clog2(BIN_W + 1);

  bcd_state_t          state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic                in_ready_d, out_valid_d, ovf_d;
  logic [BCD_W-1:0]    bcd_d;
  logic [DIGITS-1:0]   en_d, en_c;
  logic [BCD_W-1:0]    adj_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc_q[4*g +: 4]),
      .adj_c (adj_c[4*g +: 4])
    );
  end

`ifdef BCD_LZB_EN
  // A digit is lit when its value or any more significant digit is nonzero.
  always_comb begin
    en_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) en_c[i] = (acc_q >> (4 * i)) != '0;
    en_c[0] = 1'b1;
    if (sticky_q) en_c = '1;
  end
`else
  assign en_c = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    bcd_d       = bcd_out;
    ovf_d       = ovf;
    en_d        = digit_en;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d    = idata;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Adjusted top bit leaving the accumulator means the value does not fit.
        acc_d    = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d    = bin_q << 1;
        sticky_d = sticky_q | adj_c[BCD_W-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d       = sticky_q ? {DIGITS{BCD_NINE}} : acc_q;
        ovf_d       = sticky_q;
        en_d        = en_c;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      digit_en  <= DIGITS'(1);
    end else begin
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      bcd_out   <= bcd_d;
      ovf       <= ovf_d;
      digit_en  <= en_d;
    end
  end

endmodule

// File: tb/tb_bcd_display_conv.sv
// Self-checking bench: table vectors, random values against a decimal model,
// and hand-written handshake/reset sequences on three parameterisations.
module tb_bcd_display_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 16-bit, 8 digits
  logic        m_valid, m_rdy, m_ov, m_ovf;
  logic [15:0] m_data;
  logic [31:0] m_bcd;
  logic [7:0]  m_en;
  // 16-bit, 4 digits
  logic        q_valid, q_rdy, q_ov, q_ovf;
  logic [15:0] q_data;
  logic [15:0] q_bcd;
  logic [3:0]  q_en;
  // 8-bit, 3 digits
  logic        s_valid, s_rdy, s_ov, s_ovf;
  logic [7:0]  s_data;
  logic [11:0] s_bcd;
  logic [2:0]  s_en;

  bcd_display_conv #(.BIN_W(16), .DIGITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .idata(m_data), .in_ready(m_rdy),
    .out_valid(m_ov), .bcd_out(m_bcd), .ovf(m_ovf), .digit_en(m_en));
  bcd_display_conv #(.BIN_W(16), .DIGITS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(q_valid), .idata(q_data), .in_ready(q_rdy),
    .out_valid(q_ov), .bcd_out(q_bcd), .ovf(q_ovf), .digit_en(q_en));
  bcd_display_conv #(.BIN_W(8), .DIGITS(3)) u_b8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .idata(s_data), .in_ready(s_rdy),
    .out_valid(s_ov), .bcd_out(s_bcd), .ovf(s_ovf), .digit_en(s_en));

  int total = 0;
  int bad = 0;
  int hold_viol = 0;
  logic [31:0] m_prev = '0;

  // Main instance result must not move except with its out_valid pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n && m_bcd !== m_prev && !m_ov) hold_viol++;
    m_prev = m_bcd;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digits by division, overflow against 10^digits.
  function automatic void model(input longint unsigned v, input int digits,
                                output logic [39:0] bcd, output logic ovf,
                                output logic [9:0] en);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    bcd = '0;
    en  = '0;
    ovf = (v >= p);
    p = 1;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = ovf ? 4'd9 : 4'((v / p) % 10);
`ifdef BCD_LZB_EN
      en[i] = ovf || (i == 0) || (v >= p);
`else
      en[i] = 1'b1;
`endif
      p = p * 10;
    end
  endfunction

  task automatic conv_m(input logic [15:0] v, output int lat, output time acc_t,
                        output int busy_bad);
    int g;
    g = 0;
    busy_bad = 0;
    while (!m_rdy && g < 50) begin @(negedge clk); g++; end
    m_valid = 1'b1;
    m_data  = v;
    @(posedge clk);
    acc_t = $time;
    #1 m_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!m_ov && m_rdy) busy_bad++;
    end while (!m_ov && lat < 50);
    @(negedge clk);
  endtask

  task automatic conv_q(input logic [15:0] v, output int lat);
    int g;
    g = 0;
    while (!q_rdy && g < 50) begin @(negedge clk); g++; end
    q_valid = 1'b1;
    q_data  = v;
    @(posedge clk); #1 q_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!q_ov && lat < 50);
    @(negedge clk);
  endtask

  task automatic conv_s(input logic [7:0] v, output int lat);
    int g;
    g = 0;
    while (!s_rdy && g < 50) begin @(negedge clk); g++; end
    s_valid = 1'b1;
    s_data  = v;
    @(posedge clk); #1 s_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!s_ov && lat < 50);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] val;
    logic [31:0] bcd;
    logic [7:0]  en_lzb;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    int          lat, busy, cnt, g;
    time         t_acc, t_prev;
    logic [39:0] e_bcd;
    logic        e_ovf;
    logic [9:0]  e_en;
    logic [15:0] v;
    logic [7:0]  exp_en;

    vecs[0] = '{16'd1234,  32'h00001234, 8'h0F};
    vecs[1] = '{16'd65535, 32'h00065535, 8'h1F};
    vecs[2] = '{16'd0,     32'h00000000, 8'h01};
    vecs[3] = '{16'd9,     32'h00000009, 8'h01};
    vecs[4] = '{16'd10,    32'h00000010, 8'h03};
    vecs[5] = '{16'd40960, 32'h00040960, 8'h1F};
    vecs[6] = '{16'd1,     32'h00000001, 8'h01};
    vecs[7] = '{16'd1000,  32'h00001000, 8'h0F};

    rst_n = 1'b0;
    m_valid = 1'b0; m_data = '0;
    q_valid = 1'b0; q_data = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", m_rdy, 1'b1);
    chk("rst out_valid", m_ov, 1'b0);
    chk("rst bcd_out", m_bcd, 32'h0);
    chk("rst ovf", m_ovf, 1'b0);
    chk("rst digit_en", m_en, 8'h01);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back to back in each out_valid cycle.
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef BCD_LZB_EN
      exp_en = vecs[i].en_lzb;
`else
      exp_en = 8'hFF;
`endif
      conv_m(vecs[i].val, lat, t_acc, busy);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
      chk($sformatf("vec%0d bcd", i), m_bcd, vecs[i].bcd);
      chk($sformatf("vec%0d ovf", i), m_ovf, 1'b0);
      chk($sformatf("vec%0d en", i), m_en, exp_en);
      chk($sformatf("vec%0d busy ready", i), 64'(busy), 64'd0);
      if (i > 0) chk($sformatf("vec%0d spacing", i), 64'(t_acc - t_prev), 64'd180);
      t_prev = t_acc;
    end

    // Random values against the decimal model.
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom);
      model(64'(v), 8, e_bcd, e_ovf, e_en);
      conv_m(v, lat, t_acc, busy);
      chk($sformatf("rnd %0d bcd", v), m_bcd, e_bcd[31:0]);
      chk($sformatf("rnd %0d en", v), m_en, e_en[7:0]);
      chk($sformatf("rnd %0d ovf", v), m_ovf, e_ovf);
    end

    // in_valid held high with idata toggling while busy.
    v = 16'd4711;
    m_valid = 1'b1;
    m_data  = v;
    @(posedge clk); #1;
    cnt = 0;
    g = 0;
    while (!m_ov && g < 50) begin
      m_data = 16'($urandom);
      @(posedge clk); #1;
      g++;
      if (!m_ov && m_rdy) cnt++;
    end
    m_valid = 1'b0;
    chk("hold latency", 64'(g), 64'd17);
    chk("hold bcd", m_bcd, 32'h00004711);
    chk("hold ready low", 64'(cnt), 64'd0);
    cnt = 0;
    repeat (25) begin @(posedge clk); #1; if (m_ov) cnt++; end
    chk("hold extra pulses", 64'(cnt), 64'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    m_valid = 1'b1;
    m_data  = 16'hBEEF;
    @(posedge clk); #1 m_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", m_rdy, 1'b1);
    chk("midrst out_valid", m_ov, 1'b0);
    chk("midrst bcd_out", m_bcd, 32'h0);
    chk("midrst ovf", m_ovf, 1'b0);
    chk("midrst digit_en", m_en, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (m_ov) cnt++; end
    chk("midrst no pulse", 64'(cnt), 64'd0);
    @(negedge clk);
    model(64'd42, 8, e_bcd, e_ovf, e_en);
    conv_m(16'd42, lat, t_acc, busy);
    chk("after rst bcd", m_bcd, 32'h00000042);
    chk("after rst en", m_en, e_en[7:0]);
    chk("hold violations", 64'(hold_viol), 64'd0);

    // Four-digit instance: saturation boundary.
    conv_q(16'd12345, lat);
    chk("d4 12345 bcd", q_bcd, 16'h9999);
    chk("d4 12345 ovf", q_ovf, 1'b1);
    chk("d4 12345 en", q_en, 4'hF);
    chk("d4 latency", 64'(lat), 64'd17);
    conv_q(16'd9999, lat);
    chk("d4 9999 bcd", q_bcd, 16'h9999);
    chk("d4 9999 ovf", q_ovf, 1'b0);
    conv_q(16'd10000, lat);
    chk("d4 10000 ovf", q_ovf, 1'b1);
    conv_q(16'd7, lat);
    model(64'd7, 4, e_bcd, e_ovf, e_en);
    chk("d4 7 bcd", q_bcd, 16'h0007);
    chk("d4 7 en", q_en, e_en[3:0]);
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom);
      model(64'(v), 4, e_bcd, e_ovf, e_en);
      conv_q(v, lat);
      chk($sformatf("d4 rnd %0d bcd", v), q_bcd, e_bcd[15:0]);
      chk($sformatf("d4 rnd %0d ovf", v), q_ovf, e_ovf);
      chk($sformatf("d4 rnd %0d en", v), q_en, e_en[3:0]);
    end

    // Eight-bit instance: full sweep.
    for (int i = 0; i < 256; i++) begin
      model(64'(i), 3, e_bcd, e_ovf, e_en);
      conv_s(8'(i), lat);
      chk($sformatf("sweep %0d bcd", i), s_bcd, e_bcd[11:0]);
      chk($sformatf("sweep %0d ovf", i), s_ovf, 1'b0);
      if (i == 0 || i == 255) chk($sformatf("sweep %0d latency", i), 64'(lat), 64'd9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
